// File: rtl/disp_scan_if.sv
// Bundle of frame inputs and display outputs for the seven-segment scan controller.
// The master drives the system data; the slave (scan controller) drives the pins.
interface disp_scan_if #(
  parameter int DIGITS = 8
);
  logic                  en;
  logic [4*DIGITS-1:0]   hexs;
  logic [DIGITS-1:0]     points;
  logic [DIGITS-1:0]     les;
  logic [DIGITS-1:0]     blink;
  logic [3:0]            bright;
  logic [3:0]            hex;
  logic                  p;
  logic                  le;
  logic [DIGITS-1:0]     an;
  logic                  frame_start;

  modport master (
    output en, hexs, points, les, blink, bright,
    input  hex, p, le, an, frame_start
  );

  modport slave (
    input  en, hexs, points, les, blink, bright,
    output hex, p, le, an, frame_start
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Self-timed multiplexed seven-segment scan controller with frame snapshot,
// anti-ghost guard cycle, 16-level PWM brightness and per-digit blink.
module disp_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_PERIOD  = 1024,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  disp_scan_if.slave bus
);

  localparam int IW = $clog2(DIGITS);
  localparam int TW = $clog2(SCAN_PERIOD);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TW-1:0]               tick;
  logic [IW-1:0]               idx;
  logic [3:0]                  pwm;
  logic [FW-1:0]               frame_cnt;
  logic                        blink_ph;
  logic                        primed;

  logic [DIGITS-1:0][3:0]      sh_hex;
  logic [DIGITS-1:0]           sh_points;
  logic [DIGITS-1:0]           sh_les;
  logic [DIGITS-1:0]           sh_blink;

  logic                        tick_last;
  logic                        idx_last;
  logic                        frame_wrap;
  logic                        frame_last;
  logic                        snap;
  logic                        lit;
  logic [DIGITS-1:0]           an_next;

  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves a signal unassigned and no latch is inferred.
    an_next    = '1;
    tick_last  = (tick == TW'(SCAN_PERIOD - 1));
    idx_last   = (idx == IW'(DIGITS - 1));
    frame_wrap = tick_last && idx_last;
    frame_last = (frame_cnt == FW'(BLINK_FRAMES - 1));
    // Capture on the frame wrap, and once on the first enabled cycle after reset.
    snap       = bus.en && (!primed || frame_wrap);
    // Tick 0 of every slot is the all-dark guard cycle that hides anode switching.
    lit        = (tick != '0) && (pwm <= bus.bright) && !(blink_ph && sh_blink[idx]);
    if (bus.en && lit) an_next[idx] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick            <= '0;
      idx             <= '0;
      pwm             <= '0;
      frame_cnt       <= '0;
      blink_ph        <= 1'b0;
      primed          <= 1'b0;
      // NOTE: the shadow frame is small register state, not RAM, so it is
      // cleared with everything else to make the first frame well defined.
      sh_hex          <= '0;
      sh_points       <= '0;
      sh_les          <= '0;
      sh_blink        <= '0;
      bus.hex         <= 4'd0;
      bus.p           <= 1'b0;
      bus.le          <= 1'b0;
      bus.an          <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      if (bus.en) begin
        pwm    <= pwm + 4'd1;
        primed <= 1'b1;
        if (tick_last) begin
          tick <= '0;
          idx  <= idx_last ? '0 : idx + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
        if (frame_wrap) begin
          if (frame_last) begin
            frame_cnt <= '0;
            blink_ph  <= ~blink_ph;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        if (snap) begin
          sh_hex    <= bus.hexs;
          sh_points <= bus.points;
          sh_les    <= bus.les;
          sh_blink  <= bus.blink;
        end
        // Digit data tracks the slot even while its anode is dark.
        bus.hex <= sh_hex[idx];
        bus.p   <= sh_points[idx];
        bus.le  <= sh_les[idx];
      end
      bus.an          <= an_next;
      bus.frame_start <= bus.en && (idx == '0) && (tick == '0);
    end
  end

endmodule
